// File: rtl/alu_seq_if.sv
// Request/response bundle between a MIPS datapath controller and alu_seq_unit.
interface alu_seq_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         aluop;
  logic [5:0]         functioncode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               overflow;
  logic               illegal;
  logic               busy;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  // Requester side
  modport master (
    output in_valid, aluop, functioncode, shamt, a, b,
    input  in_ready, out_valid, result, zero, overflow, illegal, busy, hi, lo
  );

  // Execute-unit side
  modport slave (
    input  in_valid, aluop, functioncode, shamt, a, b,
    output in_ready, out_valid, result, zero, overflow, illegal, busy, hi, lo
  );
endinterface

// File: rtl/alu_seq_unit.sv
// ALU control decode plus execute: single-cycle ops and an iterative
// shift-add unsigned multiplier writing HI/LO.
module alu_seq_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic  clk,
  input  logic  reset,
  alu_seq_if.slave bus
);

  localparam int unsigned CNT_W = SHAMT_W;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_MFHI, OP_MFLO, OP_MULTU, OP_ILL
  } op_t;

  state_t             state, state_nxt;
  op_t                op;
  logic               accept;
  logic               mul_last;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH:0]     psum;
  logic [WIDTH-1:0]   sum, diff, res_c;
  logic               ovf_c, ill_c;

  assign bus.in_ready = (state == S_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_last     = (cnt == CNT_W'(WIDTH - 1));

  // Decode aluop/functioncode into an operation
  always_comb begin
    op = OP_ILL;
    case (bus.aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_OR;
      default: begin
        case (bus.functioncode)
          6'b000000: op = OP_SLL;
          6'b000010: op = OP_SRL;
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100110: op = OP_XOR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          6'b101011: op = OP_SLTU;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          6'b011001: op = OP_MULTU;
          default:   op = OP_ILL;
        endcase
      end
    endcase
  end

  // Single-cycle result, signed overflow and illegal flag
  always_comb begin
    sum   = bus.a + bus.b;
    diff  = bus.a - bus.b;
    res_c = '0;
    ovf_c = 1'b0;
    ill_c = (op == OP_ILL);
    case (op)
      OP_ADD: begin
        res_c = sum;
        ovf_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff;
        ovf_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  res_c = bus.a & bus.b;
      OP_OR:   res_c = bus.a | bus.b;
      OP_XOR:  res_c = bus.a ^ bus.b;
      OP_NOR:  res_c = ~(bus.a | bus.b);
      OP_SLT:  res_c = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: res_c = WIDTH'(bus.a < bus.b);
      OP_SLL:  res_c = bus.b << bus.shamt;
      OP_SRL:  res_c = bus.b >> bus.shamt;
      OP_MFHI: res_c = bus.hi;
      OP_MFLO: res_c = bus.lo;
      default: res_c = '0;
    endcase
  end

  // One shift-add step: add multiplicand into upper half, shift right
  always_comb begin
    psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step = (2*WIDTH)'({psum, acc[WIDTH-1:0]} >> 1);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: enter MUL on multu accept, leave after WIDTH steps
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && op == OP_MULTU) state_nxt = S_MUL;
      S_MUL:   if (mul_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.hi        <= '0;
      bus.lo        <= '0;
      cnt           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MULTU) begin
              mcand    <= bus.a;
              mplier   <= bus.b;
              acc      <= '0;
              cnt      <= '0;
              bus.busy <= 1'b1;
            end else begin
              bus.result    <= res_c;
              bus.zero      <= (res_c == '0);
              bus.overflow  <= ovf_c;
              bus.illegal   <= ill_c;
              bus.out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (mul_last) begin
            bus.hi        <= acc_step[2*WIDTH-1:WIDTH];
            bus.lo        <= acc_step[WIDTH-1:0];
            bus.result    <= acc_step[WIDTH-1:0];
            bus.zero      <= (acc_step[WIDTH-1:0] == '0);
            bus.overflow  <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b0;
            cnt           <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit.
module tb_alu_seq_unit;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  alu_seq_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Present one request for exactly one clock edge; sample #1 after it
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] av, input logic [31:0] bv);
    bus.aluop        = op;
    bus.functioncode = fn;
    bus.shamt        = sh;
    bus.a            = av;
    bus.b            = bv;
    bus.in_valid     = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b0;
  endtask

  // Wait (bounded) for out_valid, counting edges; in_ready must stay low meanwhile
  task automatic wait_done(output int n, output logic ready_seen);
    n = 0;
    ready_seen = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) break;
      if (bus.in_ready || !bus.busy) ready_seen = 1'b1;
    end
    bus.in_valid = 1'b0;
  endtask

  int   n;
  logic rdy;

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid     = 1'b0;
    bus.aluop        = 2'b00;
    bus.functioncode = 6'b0;
    bus.shamt        = 5'd0;
    bus.a            = '0;
    bus.b            = '0;
    reset            = 1'b1;
    #22;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_result",    64'(bus.result),    64'd0);
    check("rst_hilo",      {bus.hi, bus.lo},   64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // add 5+7
    issue(2'b00, 6'b0, 5'd0, 32'd5, 32'd7);
    check("add_valid", 64'(bus.out_valid), 64'd1);
    check("add_res",   64'(bus.result),    64'd12);
    check("add_zero",  64'(bus.zero),      64'd0);
    check("add_ovf",   64'(bus.overflow),  64'd0);
    @(posedge clk); #1;
    check("pulse_drop", 64'(bus.out_valid), 64'd0);
    check("res_hold",   64'(bus.result),    64'd12);

    // R-type sub to zero, then add overflow
    issue(2'b10, 6'b100010, 5'd0, 32'd9, 32'd9);
    check("sub_res",  64'(bus.result), 64'd0);
    check("sub_zero", 64'(bus.zero),   64'd1);
    issue(2'b00, 6'b0, 5'd0, 32'h7FFF_FFFF, 32'd1);
    check("addov_res", 64'(bus.result),   64'h8000_0000);
    check("addov_ovf", 64'(bus.overflow), 64'd1);
    check("addov_z",   64'(bus.zero),     64'd0);
    issue(2'b01, 6'b0, 5'd0, 32'h8000_0000, 32'd1);
    check("subov_res", 64'(bus.result),   64'h7FFF_FFFF);
    check("subov_ovf", 64'(bus.overflow), 64'd1);

    // back-to-back slt / sltu
    issue(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("slt_valid", 64'(bus.out_valid), 64'd1);
    check("slt_res",   64'(bus.result),    64'd1);
    check("slt_ovf",   64'(bus.overflow),  64'd0);
    issue(2'b10, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("sltu_valid", 64'(bus.out_valid), 64'd1);
    check("sltu_res",   64'(bus.result),    64'd0);

    // logic ops
    issue(2'b11, 6'b111111, 5'd7, 32'h0000_00F0, 32'h0000_000F);
    check("or_res",  64'(bus.result), 64'h0000_00FF);
    check("or_ill",  64'(bus.illegal), 64'd0);
    issue(2'b10, 6'b100100, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_res", 64'(bus.result), 64'h00F0_1200);
    issue(2'b10, 6'b100110, 5'd0, 32'hFFFF_0000, 32'h0F0F_0F0F);
    check("xor_res", 64'(bus.result), 64'hF0F0_0F0F);
    issue(2'b10, 6'b100111, 5'd0, 32'd0, 32'd0);
    check("nor_res", 64'(bus.result), 64'hFFFF_FFFF);

    // multu 0xFFFFFFFF * 2 with ignored requests during busy
    issue(2'b10, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'd2);
    check("mul_acc_busy",  64'(bus.busy),      64'd1);
    check("mul_acc_rdy",   64'(bus.in_ready),  64'd0);
    check("mul_acc_valid", 64'(bus.out_valid), 64'd0);
    bus.aluop = 2'b00; bus.a = 32'd1; bus.b = 32'd1; bus.in_valid = 1'b1;
    wait_done(n, rdy);
    check("mul_latency", 64'(n),            64'd32);
    check("mul_ready_lo",64'(rdy),          64'd0);
    check("mul_valid",   64'(bus.out_valid),64'd1);
    check("mul_hi",      64'(bus.hi),       64'd1);
    check("mul_lo",      64'(bus.lo),       64'hFFFF_FFFE);
    check("mul_res",     64'(bus.result),   64'hFFFF_FFFE);
    check("mul_busy",    64'(bus.busy),     64'd0);
    check("mul_rdy",     64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    check("no_queue",    64'(bus.out_valid),64'd0);
    check("no_queue_res",64'(bus.result),   64'hFFFF_FFFE);
    issue(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
    check("mfhi", 64'(bus.result), 64'd1);
    issue(2'b10, 6'b010010, 5'd0, 32'd0, 32'd0);
    check("mflo", 64'(bus.result), 64'hFFFF_FFFE);

    // multu with zero low product
    issue(2'b10, 6'b011001, 5'd0, 32'h0001_0000, 32'h0001_0000);
    wait_done(n, rdy);
    check("mul2_latency", 64'(n),          64'd32);
    check("mul2_hilo",    {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    check("mul2_zero",    64'(bus.zero),   64'd1);

    // reset at iteration 10 of 3*4
    issue(2'b10, 6'b011001, 5'd0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_busy",  64'(bus.busy),      64'd0);
    check("abort_rdy",   64'(bus.in_ready),  64'd1);
    check("abort_hilo",  {bus.hi, bus.lo},   64'd0);
    check("abort_res",   64'(bus.result),    64'd0);
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    #2 reset = 1'b0;
    n = 0;
    repeat (34) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    check("abort_no_valid", 64'(n), 64'd0);
    issue(2'b00, 6'b0, 5'd0, 32'd2, 32'd3);
    check("post_add_valid", 64'(bus.out_valid), 64'd1);
    check("post_add_res",   64'(bus.result),    64'd5);

    // illegal funct, then shifts
    issue(2'b10, 6'b111111, 5'd0, 32'h1234_5678, 32'h1);
    check("ill_flag",  64'(bus.illegal),   64'd1);
    check("ill_res",   64'(bus.result),    64'd0);
    check("ill_valid", 64'(bus.out_valid), 64'd1);
    check("ill_zero",  64'(bus.zero),      64'd1);
    issue(2'b10, 6'b000000, 5'd31, 32'hFFFF_FFFF, 32'd1);
    check("sll_res", 64'(bus.result),  64'h8000_0000);
    check("sll_ill", 64'(bus.illegal), 64'd0);
    issue(2'b10, 6'b000010, 5'd4, 32'h0, 32'h0000_00F0);
    check("srl_res", 64'(bus.result), 64'h0000_000F);
    issue(2'b10, 6'b000010, 5'd31, 32'h0, 32'h8000_0000);
    check("srl31_res", 64'(bus.result), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
